// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
//   Shared types and constants for the CPU front end.
//   - XLEN           : machine word width (32)
//   - RESET_PC_DEF   : default PC after reset
//   - NOP_INSTR_DEF  : bubble encoding (addi x0,x0,0)
//   - fetch_state_e  : fetch FSM states (REQ, FULL)
//   - fetch_entry_t  : one buffered fetch result {pc, pc_4, instr[, misalign]}
//   - pc_plus4 / word_align : PC arithmetic helpers (modulo 2^XLEN)
//   Build option: IF_MISALIGN_CHK_EN adds the misalign flag to fetch_entry_t.
// ----------------------------------------------------------------------------
package cpu_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEF  = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0013;

    typedef enum logic {
        ST_REQ  = 1'b0,   // request outstanding (or about to be issued)
        ST_FULL = 1'b1    // one instruction held for decode, no request
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_4;
        logic [XLEN-1:0] instr;
`ifdef IF_MISALIGN_CHK_EN
        logic            misalign;
`endif
    } fetch_entry_t;

    // Wraps naturally: 32'hFFFF_FFFC + 4 = 0.
    function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] pc);
        return pc & ~32'h3;
    endfunction

endpackage

// File: rtl/if_fetch_buf.sv
// ----------------------------------------------------------------------------
// if_fetch_buf
//   Single-entry holding register for a fetched instruction. The owner decides
//   when to load and when to drop the entry; this block only stores it.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     i_load       capture i_entry and mark valid (wins over i_clear)
//     i_clear      drop the entry (valid <= 0, contents kept)
//     i_entry      entry to capture
//     o_valid      entry present
//     o_entry      stored entry (all zero after reset)
// ----------------------------------------------------------------------------
module if_fetch_buf
    import cpu_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic         i_clear,
    input  fetch_entry_t i_entry,
    output logic         o_valid,
    output fetch_entry_t o_entry
);

    logic         r_valid;
    fetch_entry_t r_entry;

    // NOTE: the data register is reset too, not just the valid bit, because
    // decode-facing outputs must read as zero while reset is applied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_entry <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_entry <= i_entry;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_entry = r_entry;

endmodule

// File: rtl/if_fetch_unit.sv
// ----------------------------------------------------------------------------
// if_fetch_unit
//   Instruction-fetch front end. Owns the architectural PC, issues req/ack
//   reads to instruction memory, holds one returned instruction for decode
//   (valid/ready) and handles EX-stage redirects.
//   Parameters:
//     RESET_PC    PC loaded on reset (first fetch address)
//     NOP_INSTR   word presented for a misaligned redirect
//   Ports:
//     clk, rst_n               clock, asynchronous active-low reset
//     redirect_vld/redirect_pc EX redirect strobe and target
//     imem_req/imem_addr       memory read request, address stable while req=1
//     imem_ack/imem_rdata      one-cycle completion pulse with data
//     if_valid/if_ready        decode handshake
//     if_pc/if_pc_4/if_instr   buffered instruction, its PC and PC+4
//     if_misalign              only with IF_MISALIGN_CHK_EN
//   Build option IF_MISALIGN_CHK_EN: a misaligned redirect target skips the
//   memory and is presented directly as a NOP flagged if_misalign. Without it
//   redirect_pc[1:0] is ignored (treated as 2'b00).
// ----------------------------------------------------------------------------
module if_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_vld,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_pc_4,
    output logic [XLEN-1:0] if_instr
`ifdef IF_MISALIGN_CHK_EN
   ,output logic            if_misalign
`endif
);

    fetch_state_e    r_state, w_state_nxt;
    logic [XLEN-1:0] r_pc, w_pc_nxt;
    logic            r_pend, w_pend_nxt;
    logic [XLEN-1:0] r_pend_pc, w_pend_pc_nxt;
    // Low during reset and for the first cycle after it, so no request (and no
    // stray ack) is honoured until the unit is actually running.
    logic            r_active;

    logic            w_req, w_ack;
    logic [XLEN-1:0] w_redir_pc, w_tgt;
    logic            w_tgt_mis, w_take_redir;
    logic            w_buf_load, w_buf_clear, w_buf_valid;
    fetch_entry_t    w_buf_d, w_buf_q;

`ifdef IF_MISALIGN_CHK_EN
    assign w_redir_pc = redirect_pc;
`else
    assign w_redir_pc = word_align(redirect_pc);
`endif

    assign w_req = r_active && (r_state == ST_REQ);
    assign w_ack = w_req && imem_ack;

    // A redirect arriving this cycle beats one remembered from earlier.
    assign w_tgt = redirect_vld ? w_redir_pc : r_pend_pc;

`ifdef IF_MISALIGN_CHK_EN
    assign w_tgt_mis = |w_tgt[1:0];
`else
    assign w_tgt_mis = 1'b0;
`endif

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_pend_nxt    = r_pend;
        w_pend_pc_nxt = r_pend_pc;
        w_take_redir  = 1'b0;
        w_buf_load    = 1'b0;
        w_buf_clear   = 1'b0;
        w_buf_d       = '0;
        w_buf_d.pc    = r_pc;
        w_buf_d.pc_4  = pc_plus4(r_pc);
        w_buf_d.instr = imem_rdata;

        unique case (r_state)
            ST_REQ: begin
                if (w_ack) begin
                    if (redirect_vld || r_pend) begin
                        // Returned word belongs to the wrong path: drop it.
                        w_pend_nxt   = 1'b0;
                        w_take_redir = 1'b1;
                    end else begin
                        w_buf_load  = 1'b1;
                        w_pc_nxt    = pc_plus4(r_pc);
                        w_state_nxt = ST_FULL;
                    end
                end else if (redirect_vld) begin
                    // Address must stay stable until ack; remember the target.
                    w_pend_nxt    = 1'b1;
                    w_pend_pc_nxt = w_redir_pc;
                end
            end
            ST_FULL: begin
                if (redirect_vld) begin
                    w_buf_clear  = 1'b1;
                    w_take_redir = 1'b1;
                end else if (if_ready) begin
                    w_buf_clear = 1'b1;
                    w_state_nxt = ST_REQ;
                end
            end
            default: ;
        endcase

        if (w_take_redir) begin
            if (w_tgt_mis) begin
                // Misaligned target: present a flagged bubble, no memory read.
                w_buf_load    = 1'b1;
                w_buf_d.pc    = w_tgt;
                w_buf_d.pc_4  = pc_plus4(w_tgt);
                w_buf_d.instr = NOP_INSTR;
`ifdef IF_MISALIGN_CHK_EN
                w_buf_d.misalign = 1'b1;
`endif
                w_pc_nxt      = pc_plus4(word_align(w_tgt));
                w_state_nxt   = ST_FULL;
            end else begin
                w_pc_nxt    = w_tgt;
                w_state_nxt = ST_REQ;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_REQ;
            r_pc      <= RESET_PC;
            r_pend    <= 1'b0;
            r_pend_pc <= '0;
            r_active  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_pend    <= w_pend_nxt;
            r_pend_pc <= w_pend_pc_nxt;
            r_active  <= 1'b1;
        end
    end

    if_fetch_buf u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_buf_load),
        .i_clear (w_buf_clear),
        .i_entry (w_buf_d),
        .o_valid (w_buf_valid),
        .o_entry (w_buf_q)
    );

    assign imem_req  = w_req;
    assign imem_addr = r_pc;
    assign if_valid  = w_buf_valid;
    assign if_pc     = w_buf_q.pc;
    assign if_pc_4   = w_buf_q.pc_4;
    assign if_instr  = w_buf_q.instr;
`ifdef IF_MISALIGN_CHK_EN
    assign if_misalign = w_buf_valid && w_buf_q.misalign;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_if_fetch_unit
//   Self-checking bench for if_fetch_unit. A memory responder with a
//   configurable ack latency feeds the DUT; a transaction-level reference
//   model predicts the request address, the held instruction and the decode
//   handshake every cycle. Directed scenarios run first, then random traffic.
//   Honours IF_MISALIGN_CHK_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_vld = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_pc, if_pc_4, if_instr;
`ifdef IF_MISALIGN_CHK_EN
    logic        if_misalign;
`endif

    if_fetch_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .redirect_vld (redirect_vld),
        .redirect_pc  (redirect_pc),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .if_valid     (if_valid),
        .if_ready     (if_ready),
        .if_pc        (if_pc),
        .if_pc_4      (if_pc_4),
        .if_instr     (if_instr)
`ifdef IF_MISALIGN_CHK_EN
       ,.if_misalign  (if_misalign)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    bit          m_req;       // a fetch is being requested
    bit          m_valid;     // an instruction is offered to decode
    bit          m_mis;       // offered instruction is a misalign bubble
    bit          m_stale;     // current fetch was overtaken by a redirect
    logic [31:0] m_addr;      // address of the (next) fetch
    logic [31:0] m_pc, m_instr, m_stale_pc;
    int          mem_wait, mem_lat, lat_fixed;
    logic [31:0] dut_seen[$]; // PCs decode actually accepted

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h5A3C_96E1;
    endfunction

    function automatic int pick_lat();
        return (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 3));
    endfunction

    function automatic logic [31:0] norm_tgt(input logic [31:0] t);
`ifdef IF_MISALIGN_CHK_EN
        return t;
`else
        return t & 32'hFFFF_FFFC;
`endif
    endfunction

    // Begin fetching from t (or, for a misaligned t, offer the bubble).
    task automatic launch(input logic [31:0] t);
        m_valid = 1'b0;
        m_mis   = 1'b0;
        m_req   = 1'b1;
        m_addr  = t;
`ifdef IF_MISALIGN_CHK_EN
        if (t[1:0] != 2'b00) begin
            m_valid = 1'b1;
            m_mis   = 1'b1;
            m_pc    = t;
            m_instr = 32'h0000_0013;
            m_req   = 1'b0;
            m_addr  = (t & 32'hFFFF_FFFC) + 32'd4;
        end
`endif
    endtask

    // One clock cycle: compare DUT with the model, drive this cycle's inputs,
    // then advance the model across the coming rising edge.
    task automatic step(input bit redir, input logic [31:0] rpc, input bit ready);
        bit          ack;
        logic [31:0] tgt;
        @(negedge clk);
        check("imem_req", imem_req, m_req);
        if (m_req) check("imem_addr", imem_addr, m_addr);
        check("if_valid", if_valid, m_valid);
        if (m_valid) begin
            check("if_pc", if_pc, m_pc);
            check("if_pc_4", if_pc_4, m_pc + 32'd4);
            check("if_instr", if_instr, m_instr);
        end
`ifdef IF_MISALIGN_CHK_EN
        check("if_misalign", if_misalign, m_valid && m_mis);
`endif
        ack = 1'b0;
        if (m_req) begin
            if (mem_wait >= mem_lat) begin
                ack      = 1'b1;
                mem_wait = 0;
                mem_lat  = pick_lat();
            end else begin
                mem_wait++;
            end
        end
        imem_ack     = ack;
        imem_rdata   = ack ? mem_word(m_addr) : $urandom;
        redirect_vld = redir;
        redirect_pc  = rpc;
        if_ready     = ready;
        if (if_valid && ready && !redir) dut_seen.push_back(if_pc);

        tgt = norm_tgt(rpc);
        if (m_valid) begin
            if (redir) launch(tgt);
            else if (ready) begin
                m_valid = 1'b0;
                m_mis   = 1'b0;
                m_req   = 1'b1;
            end
        end else if (m_req && ack) begin
            if (redir || m_stale) begin
                m_stale = 1'b0;
                launch(redir ? tgt : m_stale_pc);
            end else begin
                m_valid = 1'b1;
                m_mis   = 1'b0;
                m_pc    = m_addr;
                m_instr = mem_word(m_addr);
                m_req   = 1'b0;
                m_addr  = m_addr + 32'd4;
            end
        end else if (redir) begin
            m_stale    = 1'b1;
            m_stale_pc = tgt;
        end
    endtask

    // Asynchronous reset in the middle of a cycle, with a late ack on the bus
    // both during reset and in the release cycle.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_req_now", imem_req, 1'b0);
        check("rst_valid_now", if_valid, 1'b0);
        imem_ack     = 1'b1;
        imem_rdata   = $urandom;
        redirect_vld = 1'b0;
        if_ready     = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_req", imem_req, 1'b0);
        check("rst_pc", if_pc, 32'h0);
        check("rst_pc_4", if_pc_4, 32'h0);
        check("rst_instr", if_instr, 32'h0);
        rst_n    = 1'b1;
        imem_ack = 1'b1;
        m_valid  = 1'b0;
        m_mis    = 1'b0;
        m_stale  = 1'b0;
        m_addr   = 32'h0;
        mem_wait = 0;
        mem_lat  = pick_lat();
        // Across the first edge after release the unit starts requesting.
        m_req    = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] rpc;
        int          sel;

        // 1. In-order fetch, ack after 2 wait cycles, decode always ready.
        lat_fixed = 2;
        do_reset();
        dut_seen.delete();
        repeat (30) step(1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 4; i++)
            check("seq_pc", (i < dut_seen.size()) ? dut_seen[i] : 32'hDEAD_BEEF, 32'(i) * 32'd4);

        // 2. Decode stalls for 5 cycles while an instruction is held.
        for (int g = 0; g < 20 && !m_valid; g++) step(1'b0, 32'h0, 1'b0);
        repeat (5) step(1'b0, 32'h0, 1'b0);
        check("stall_req", imem_req, 1'b0);
        repeat (12) step(1'b0, 32'h0, 1'b1);

        // 3. Redirect while waiting on address 0x8: data dropped, then 0x100.
        lat_fixed = 3;
        do_reset();
        for (int g = 0; g < 50 && !(m_req && m_addr == 32'h8 && mem_wait == 0); g++)
            step(1'b0, 32'h0, 1'b1);
        step(1'b1, 32'h100, 1'b1);
        repeat (12) step(1'b0, 32'h0, 1'b1);

        // 4. Pending redirect to 0x100 overtaken by 0x200 in the ack cycle.
        for (int g = 0; g < 50 && !(m_req && mem_wait == 0 && !m_stale); g++)
            step(1'b0, 32'h0, 1'b1);
        step(1'b1, 32'h100, 1'b1);
        for (int g = 0; g < 10 && !(m_req && mem_wait >= mem_lat); g++)
            step(1'b0, 32'h0, 1'b1);
        step(1'b1, 32'h200, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        check("redir_newest", imem_addr, 32'h200);
        repeat (10) step(1'b0, 32'h0, 1'b1);

        // 5. Fetch at the top of the address space: PC+4 wraps to 0.
        lat_fixed = 1;
        step(1'b1, 32'hFFFF_FFFC, 1'b1);
        repeat (20) begin
            step(1'b0, 32'h0, 1'b1);
            if (if_valid && if_pc == 32'hFFFF_FFFC) check("wrap_pc_4", if_pc_4, 32'h0);
        end

`ifdef IF_MISALIGN_CHK_EN
        // 6. Misaligned redirect: bubble presented without a memory read.
        for (int g = 0; g < 20 && !m_valid; g++) step(1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h102, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        check("mis_req", imem_req, 1'b0);
        check("mis_pc", if_pc, 32'h102);
        check("mis_instr", if_instr, 32'h13);
        check("mis_flag", if_misalign, 1'b1);
        repeat (10) step(1'b0, 32'h0, 1'b1);
`endif

        // Reset in the middle of an outstanding request.
        for (int g = 0; g < 20 && !m_req; g++) step(1'b0, 32'h0, 1'b1);
        do_reset();
        repeat (10) step(1'b0, 32'h0, 1'b1);

        // Random traffic: random latency, stalls, redirects and resets.
        lat_fixed = -1;
        for (int n = 0; n < 4000; n++) begin
            sel = int'($urandom_range(0, 3));
            rpc = $urandom;
            if (sel == 1) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
            if (sel == 2) rpc = rpc & 32'h0000_03FF;
            if ($urandom_range(0, 599) == 0) do_reset();
            else step($urandom_range(0, 9) == 0, rpc, $urandom_range(0, 9) < 7);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
